// File: rtl/countdown_pkg.sv
// Shared types for the countdown timer.
package countdown_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} cd_state_e;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with start/hold and a one-cycle terminal-count pulse.
// Define COUNTDOWN_AUTO_RELOAD_EN to restart from the reload value at the floor.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MIN_COUNT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             hold,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  generate
    if (MIN_COUNT < 0 || (WIDTH < 31 && MIN_COUNT >= (1 << WIDTH))) begin : g_bad_min
      $error("countdown_timer: MIN_COUNT must lie in [0, 2**WIDTH)");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MIN_C  = WIDTH'(MIN_COUNT);
  // Wraps to zero when MIN_COUNT is the top value; RUN is unreachable then.
  localparam logic [WIDTH-1:0] TERM_C = MIN_C + 1'b1;

  cd_state_e        state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            if (count_q > MIN_C) begin
              state_d = RUN;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        RUN: begin
          if (hold) begin
            state_d = HOLD;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          end else if (count_q == MIN_C) begin
            if (reload_q > MIN_C) begin
              count_d = reload_q;
            end else begin
              state_d = DONE;
            end
          end else if (count_q == TERM_C) begin
            count_d = MIN_C;
            done_d  = 1'b1;
`else
          end else if (count_q <= TERM_C) begin
            count_d = MIN_C;
            done_d  = 1'b1;
            state_d = DONE;
`endif
          end else begin
            count_d = count_q - 1'b1;
          end
        end
        HOLD: begin
          if (!hold) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign done  = done_q;
  assign busy  = (state_q == RUN) || (state_q == HOLD);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: a 4-bit floor-0 instance and an 8-bit floor-3 instance.
module tb_countdown_timer;

  typedef struct {
    string      tag;
    logic [7:0] count;
    logic       busy;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_load, a_start, a_hold;
  logic [3:0] a_val, a_count;
  logic       a_busy, a_done;
  logic       b_load, b_start, b_hold;
  logic [7:0] b_val, b_count;
  logic       b_busy, b_done;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  countdown_timer #(.WIDTH(4), .MIN_COUNT(0)) dut_a (
    .clk(clk), .rst(rst), .load(a_load), .load_val(a_val), .start(a_start),
    .hold(a_hold), .count(a_count), .busy(a_busy), .done(a_done)
  );

  countdown_timer #(.WIDTH(8), .MIN_COUNT(3)) dut_b (
    .clk(clk), .rst(rst), .load(b_load), .load_val(b_val), .start(b_start),
    .hold(b_hold), .count(b_count), .busy(b_busy), .done(b_done)
  );

  task automatic compare(input bit sel);
    exp_t       e;
    logic [7:0] oc;
    logic       ob, od;
    e  = sbq.pop_front();
    oc = sel ? b_count : {4'h0, a_count};
    ob = sel ? b_busy : a_busy;
    od = sel ? b_done : a_done;
    checks++;
    assert (oc === e.count) else begin
      errors++;
      $error("FAIL %s count: got %0d expected %0d", e.tag, oc, e.count);
    end
    checks++;
    assert (ob === e.busy) else begin
      errors++;
      $error("FAIL %s busy: got %b expected %b", e.tag, ob, e.busy);
    end
    checks++;
    assert (od === e.done) else begin
      errors++;
      $error("FAIL %s done: got %b expected %b", e.tag, od, e.done);
    end
    $display("[%0t] %s dut=%s count=%0d busy=%b done=%b", $time, e.tag,
             sel ? "B" : "A", oc, ob, od);
  endtask

  // One clock: drive the selected instance, expect its outputs after the edge.
  task automatic step(input bit sel, input string tag, input logic ld, input logic [7:0] v,
                      input logic st, input logic hd,
                      input logic [7:0] ec, input logic eb, input logic ed);
    @(negedge clk);
    a_load = 1'b0; a_start = 1'b0; a_hold = 1'b0; a_val = '0;
    b_load = 1'b0; b_start = 1'b0; b_hold = 1'b0; b_val = '0;
    if (!sel) begin
      a_load = ld; a_val = v[3:0]; a_start = st; a_hold = hd;
    end else begin
      b_load = ld; b_val = v; b_start = st; b_hold = hd;
    end
    sbq.push_back('{tag, ec, eb, ed});
    @(posedge clk);
    #1;
    compare(sel);
  endtask

  task automatic check_now(input bit sel, input string tag,
                           input logic [7:0] ec, input logic eb, input logic ed);
    sbq.push_back('{tag, ec, eb, ed});
    compare(sel);
  endtask

  initial begin
    rst = 1'b1;
    a_load = 1'b0; a_start = 1'b0; a_hold = 1'b0; a_val = '0;
    b_load = 1'b0; b_start = 1'b0; b_hold = 1'b0; b_val = '0;
    repeat (2) @(negedge clk);
    check_now(0, "reset", 8'd0, 1'b0, 1'b0);
    check_now(1, "reset", 8'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Hold outside RUN is ignored; load captures directly.
    step(0, "load4",     1, 8'd4, 0, 0, 8'd4, 0, 0);
    step(0, "idle_hold", 0, 8'd0, 0, 1, 8'd4, 0, 0);

    // Asynchronous reset in the middle of a run.
    step(0, "rst_load",  1, 8'd9, 0, 0, 8'd9, 0, 0);
    step(0, "rst_start", 0, 8'd0, 1, 0, 8'd9, 1, 0);
    step(0, "rst_run",   0, 8'd0, 0, 0, 8'd8, 1, 0);
    step(0, "rst_run",   0, 8'd0, 0, 0, 8'd7, 1, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_now(0, "rst_async", 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step(0, "rst_after", 0, 8'd0, 1, 0, 8'd0, 0, 1);
    step(0, "rst_after", 0, 8'd0, 0, 0, 8'd0, 0, 0);

    // Mid-run load aborts without a done pulse.
    step(0, "ml_load",  1, 8'd9, 0, 0, 8'd9, 0, 0);
    step(0, "ml_start", 0, 8'd0, 1, 0, 8'd9, 1, 0);
    for (int k = 8; k >= 6; k--) step(0, "ml_run", 0, 8'd0, 0, 0, 8'(k), 1, 0);
    step(0, "ml_reload", 1, 8'd2, 0, 0, 8'd2, 0, 0);
    step(0, "ml_idle",   0, 8'd0, 0, 0, 8'd2, 0, 0);

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // Full run from 9 to the floor.
    step(0, "run9_load",  1, 8'd9, 0, 0, 8'd9, 0, 0);
    step(0, "run9_start", 0, 8'd0, 1, 0, 8'd9, 1, 0);
    for (int k = 8; k >= 1; k--) step(0, "run9", 0, 8'd0, 0, 0, 8'(k), 1, 0);
    step(0, "run9_term",  0, 8'd0, 0, 0, 8'd0, 0, 1);
    step(0, "run9_stay",  0, 8'd0, 0, 0, 8'd0, 0, 0);
    step(0, "run9_stay",  0, 8'd0, 0, 0, 8'd0, 0, 0);
    step(0, "done_start", 0, 8'd0, 1, 0, 8'd0, 0, 1);
    step(0, "done_after", 0, 8'd0, 0, 0, 8'd0, 0, 0);

    // Hold for two cycles at count 3; start during HOLD is ignored.
    step(0, "hold_load",  1, 8'd5, 0, 0, 8'd5, 0, 0);
    step(0, "hold_start", 0, 8'd0, 1, 0, 8'd5, 1, 0);
    step(0, "hold_run",   0, 8'd0, 0, 0, 8'd4, 1, 0);
    step(0, "hold_run",   0, 8'd0, 0, 0, 8'd3, 1, 0);
    step(0, "hold_1",     0, 8'd0, 0, 1, 8'd3, 1, 0);
    step(0, "hold_2",     0, 8'd0, 1, 1, 8'd3, 1, 0);
    step(0, "hold_exit",  0, 8'd0, 0, 0, 8'd3, 1, 0);
    step(0, "hold_run",   0, 8'd0, 0, 0, 8'd2, 1, 0);
    step(0, "hold_run",   0, 8'd0, 0, 0, 8'd1, 1, 0);
    step(0, "hold_term",  0, 8'd0, 0, 0, 8'd0, 0, 1);
    step(0, "hold_idle",  0, 8'd0, 0, 0, 8'd0, 0, 0);

    // Nonzero floor: 5 -> 4 -> 3 with done, restart in DONE pulses again.
    step(1, "min_load",   1, 8'd5, 0, 0, 8'd5, 0, 0);
    step(1, "min_start",  0, 8'd0, 1, 0, 8'd5, 1, 0);
    step(1, "min_run",    0, 8'd0, 0, 0, 8'd4, 1, 0);
    step(1, "min_term",   0, 8'd0, 0, 0, 8'd3, 0, 1);
    step(1, "min_stay",   0, 8'd0, 0, 0, 8'd3, 0, 0);
    step(1, "min_restart",0, 8'd0, 1, 0, 8'd3, 0, 1);
    step(1, "min_after",  0, 8'd0, 0, 0, 8'd3, 0, 0);
`else
    // Auto-reload loop: 3,2,1,0(done),3,2,1,0(done) with busy held high.
    step(0, "ar_load",  1, 8'd3, 0, 0, 8'd3, 0, 0);
    step(0, "ar_start", 0, 8'd0, 1, 0, 8'd3, 1, 0);
    for (int r = 0; r < 2; r++) begin
      step(0, "ar_run",  0, 8'd0, 0, 0, 8'd2, 1, 0);
      step(0, "ar_run",  0, 8'd0, 0, 0, 8'd1, 1, 0);
      step(0, "ar_term", 0, 8'd0, 0, 0, 8'd0, 1, 1);
      step(0, "ar_wrap", 0, 8'd0, 0, 0, 8'd3, 1, 0);
    end
    step(0, "ar_zero",  1, 8'd0, 0, 0, 8'd0, 0, 0);
    step(0, "ar_zstart",0, 8'd0, 1, 0, 8'd0, 0, 1);
    step(0, "ar_zidle", 0, 8'd0, 0, 0, 8'd0, 0, 0);
    step(0, "ar_zidle", 0, 8'd0, 0, 0, 8'd0, 0, 0);
`endif

    // Below-floor load goes straight to DONE; top value decrements cleanly.
    step(1, "low_load",  1, 8'd1, 0, 0, 8'd1, 0, 0);
    step(1, "low_start", 0, 8'd0, 1, 0, 8'd1, 0, 1);
    step(1, "low_after", 0, 8'd0, 0, 0, 8'd1, 0, 0);
    step(1, "max_load",  1, 8'd255, 0, 0, 8'd255, 0, 0);
    step(1, "max_start", 0, 8'd0, 1, 0, 8'd255, 1, 0);
    step(1, "max_run",   0, 8'd0, 0, 0, 8'd254, 1, 0);
    step(1, "max_hold",  0, 8'd0, 0, 1, 8'd254, 1, 0);
    step(1, "max_abort", 1, 8'd7, 0, 1, 8'd7, 0, 0);

    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
